// File: rtl/vga_sink_pkg.sv
// Shared 640x480@60 raster timing and FSM state type for the VGA stream sink.
package vga_sink_pkg;

    localparam int H_DISP = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;

    localparam int V_DISP = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL_DEFAULT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_DEFAULT = V_DISP + V_FP + V_SYNC + V_BP;

    typedef enum logic {
        SEARCH = 1'b0,
        RUN    = 1'b1
    } sink_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with show-ahead head data; the head word is visible before it is popped.
module stream_fifo #(
    parameter int DW    = 13,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/vga_stream_sink.sv
// Buffers a flag-tagged pixel stream and replays it on a VGA raster,
// dropping back to a search for the next frame start whenever alignment is lost.
module vga_stream_sink
    import vga_sink_pkg::*;
#(
    parameter int CD         = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int PIX_DIV    = 4,
    parameter int H_ACTIVE   = H_DISP,
    parameter int H_FRONT    = H_FP,
    parameter int H_PULSE    = H_SYNC,
    parameter int H_BACK     = H_BP,
    parameter int V_ACTIVE   = V_DISP,
    parameter int V_FRONT    = V_FP,
    parameter int V_PULSE    = V_SYNC,
    parameter int V_BACK     = V_BP
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CD:0]   si_data,
    input  logic          si_valid,
    output logic          si_ready,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic          hsync,
    output logic          vsync,
    output logic [CD-1:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DVW     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  HS_FIRST  = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0]  HS_LAST   = HW'(H_ACTIVE + H_FRONT + H_PULSE - 1);
    localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  VS_FIRST  = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0]  VS_LAST   = VW'(V_ACTIVE + V_FRONT + V_PULSE - 1);
    localparam logic [DVW-1:0] DIV_LAST  = DVW'(PIX_DIV - 1);

    sink_state_t   state;
    sink_state_t   state_next;

    logic [DVW-1:0] div_cnt;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic           pix_tick;
    logic           in_active;
    logic           at_frame_end;
    logic           at_frame_first;

    logic           fifo_push;
    logic           fifo_pop;
    logic [CD:0]    fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           head_flag;
    logic [CD-1:0]  head_rgb;

    logic           err_event;
    logic [CD-1:0]  pix_value;

    logic           force_blank;
    logic [15:0]    err_cnt;
    logic           reg_wr;
    logic           err_clear;
    logic           unused_wr_bits;

    assign fifo_push = si_valid && si_ready;
    assign si_ready  = !fifo_full;

    stream_fifo #(
        .DW    (CD + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (si_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_flag = fifo_head[0];
    assign head_rgb  = fifo_head[CD:1];

    // Free-running pixel divider and raster counters; counters only move on ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            if (pix_tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DVW'(1);
            end
            if (pix_tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + VW'(1);
                    end
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end

    assign pix_tick       = (div_cnt == DIV_LAST);
    assign in_active      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign at_frame_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign at_frame_first = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH: begin
                if (pix_tick && at_frame_end && !fifo_empty && head_flag) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (err_event) begin
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // SEARCH drains non-start words every clock; RUN consumes exactly one word per active tick.
    always_comb begin
        fifo_pop  = 1'b0;
        err_event = 1'b0;
        pix_value = '0;
        case (state)
            SEARCH: begin
                fifo_pop = !fifo_empty && !head_flag;
            end
            RUN: begin
                if (pix_tick && in_active) begin
                    if (fifo_empty) begin
                        err_event = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        if (head_flag != at_frame_first) begin
                            err_event = 1'b1;
                        end else begin
                            pix_value = head_rgb;
                        end
                    end
                end
            end
            default: begin
                fifo_pop = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= '0;
        end else if (pix_tick) begin
            hsync <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
            vsync <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
            rgb   <= force_blank ? '0 : pix_value;
        end
    end

    assign reg_wr    = cs && write && (addr == 14'd0);
    assign err_clear = reg_wr && wr_data[1];

    // A clear request in the same cycle as an error leaves the counter at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            force_blank <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (reg_wr) begin
                force_blank <= wr_data[0];
            end
            if (err_clear) begin
                err_cnt <= '0;
            end else if (err_event && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign rd_data        = {(state == RUN), 14'b0, force_blank, err_cnt};
    assign unused_wr_bits = ^wr_data[31:2];

endmodule

// File: tb/tb_vga_stream_sink.sv
// Directed bench for vga_stream_sink on a shrunken 16x9 raster (8x4 active) so several frames fit in a short run.
module tb_vga_stream_sink;

    localparam int CD     = 12;
    localparam int HT     = 16;
    localparam int VT     = 9;
    localparam int HA     = 8;
    localparam int VA     = 4;
    localparam int FRAME  = HT * VT;

    logic        clk;
    logic        reset_n;
    logic [CD:0] si_data;
    logic        si_valid;
    logic        si_ready;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        hsync;
    logic        vsync;
    logic [CD-1:0] rgb;

    int tests_run;
    int tests_failed;
    int cyc;
    int last_t;
    int accepted;
    int accepted_mark;

    logic [CD:0]   tx_q [$];
    logic [CD-1:0] exp_pix [0:4][0:31];

    vga_stream_sink #(
        .CD         (CD),
        .FIFO_DEPTH (16),
        .PIX_DIV    (4),
        .H_ACTIVE   (8),
        .H_FRONT    (2),
        .H_PULSE    (3),
        .H_BACK     (3),
        .V_ACTIVE   (4),
        .V_FRONT    (1),
        .V_PULSE    (2),
        .V_BACK     (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .si_data  (si_data),
        .si_valid (si_valid),
        .si_ready (si_ready),
        .cs       (cs),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .hsync    (hsync),
        .vsync    (vsync),
        .rgb      (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; every fourth edge is a pixel tick.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        si_valid = 1'b0;
        si_data  = '0;
        accepted = 0;
        forever begin
            @(negedge clk);
            si_valid = (tx_q.size() > 0);
            si_data  = si_valid ? tx_q[0] : '0;
            @(posedge clk);
            if (si_valid && si_ready) begin
                void'(tx_q.pop_front());
                accepted++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, last tick %0d", last_t);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [CD-1:0] val, input logic flag);
        tx_q.push_back({val, flag});
    endtask

    task automatic write_reg(input logic [31:0] data);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = 14'd0;
        wr_data = data;
        @(posedge clk);
        #1;
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = '0;
    endtask

    task automatic step_tick();
        do begin
            @(posedge clk);
            #1;
        end while ((cyc % 4) != 0);
        last_t = cyc / 4 - 1;
    endtask

    task automatic check_tick();
        int f;
        int pos;
        int h;
        int v;
        logic [CD-1:0] exp_rgb;
        step_tick();
        f   = last_t / FRAME;
        pos = last_t % FRAME;
        h   = pos % HT;
        v   = pos / HT;
        exp_rgb = '0;
        if (h < HA && v < VA && f < 5) exp_rgb = exp_pix[f][v*HA + h];
        check_output($sformatf("rgb t=%0d", last_t), 32'(rgb), 32'(exp_rgb));
        check_output($sformatf("hsync t=%0d", last_t), 32'(hsync), 32'(!(h >= 10 && h <= 12)));
        check_output($sformatf("vsync t=%0d", last_t), 32'(vsync), 32'(!(v >= 5 && v <= 6)));
    endtask

    task automatic run_until(input int target);
        while (last_t < target) check_tick();
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        last_t        = -1;
        accepted_mark = 0;
        reset_n = 1'b0;
        cs      = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        for (int f = 0; f < 5; f++)
            for (int i = 0; i < 32; i++)
                exp_pix[f][i] = '0;

        repeat (3) @(negedge clk);
        check_output("reset hsync", 32'(hsync), 32'h1);
        check_output("reset vsync", 32'(vsync), 32'h1);
        check_output("reset rgb", 32'(rgb), 32'h0);
        check_output("reset rd_data", rd_data, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("release si_ready", 32'(si_ready), 32'h1);
        check_output("release rd_data", rd_data, 32'h0);
        check_output("release hsync", 32'(hsync), 32'h1);
        check_output("release rgb", 32'(rgb), 32'h0);

        // Five stray words, then frames A and B, then the first ten words of frame C.
        run_until(5);
        for (int k = 0; k < 5; k++) apply_stimulus(12'(12'h0A0 + k), 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 32; i++) begin
                if (f == 2 && i >= 10) break;
                apply_stimulus(12'((i % HA) + (i / HA) + 16*f), i == 0);
                exp_pix[f+1][i] = 12'((i % HA) + (i / HA) + 16*f);
            end
        end

        run_until(142);
        check_output("search rd_data", rd_data, 32'h0);
        run_until(FRAME*2 - 1);
        check_output("frame1 rd_data", rd_data, 32'h8000_0000);
        run_until(FRAME*3 - 1);
        check_output("frame2 rd_data", rd_data, 32'h8000_0000);

        // Frame C runs dry at pixel 10 (h=2, v=1).
        run_until(FRAME*3 + HT + 2);
        check_output("underrun rd_data", rd_data, 32'h0000_0001);

        accepted_mark = accepted;
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(12'(12'h800 + k), k == 0);
            exp_pix[4][k] = (k < 8 || k >= 16) ? 12'(12'h800 + k) : '0;
        end
        run_until(FRAME*3 + HT + 12);
        check_output("backpressure si_ready", 32'(si_ready), 32'h0);
        check_output("backpressure accepted", 32'(accepted - accepted_mark), 32'd16);
        check_output("backpressure rd_data", rd_data, 32'h0000_0001);

        run_until(FRAME*4 + 7);
        write_reg(32'h3);
        check_output("blank on rd_data", rd_data, 32'h8001_0000);
        run_until(FRAME*4 + HT + 7);
        write_reg(32'h0);
        check_output("blank off rd_data", rd_data, 32'h8000_0000);

        run_until(FRAME*4 + 2*HT + 4);
        check_output("bp underrun rd_data", rd_data, 32'h0000_0001);
        run_until(FRAME*5 - 1);
        check_output("final si_ready", 32'(si_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vga_stream_sink.md
VGA_STREAM_SINK -- requirements
Module: vga_stream_sink

Interface
REQ-001 Parameter CD, default 12: colour depth of each pixel.
REQ-002 Parameter FIFO_DEPTH, default 16 (power of 2): stream buffer depth, in words.
REQ-003 Parameter PIX_DIV, default 4: clk cycles per pixel tick, giving 25 MHz from 100 MHz.
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: system clock.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port si_data, input, CD+1 bits: pixel stream word {rgb[CD-1:0], frame_start}.
REQ-008 Port si_valid, input, 1 bit: si_data is valid.
REQ-009 Port si_ready, output, 1 bit: sink accepts a word this cycle.
REQ-010 Port cs, write, addr[13:0], wr_data[31:0], inputs: video slot register write.
REQ-011 Port rd_data, output, 32 bits: status readback.
REQ-012 Ports hsync and vsync, outputs, 1 bit each: active-low sync signals.
REQ-013 Port rgb, output, CD bits: pixel colour.

Function
REQ-014 A word SHALL be accepted only on a cycle with si_valid=1 and si_ready=1.
REQ-015 si_ready SHALL equal "FIFO not full".
REQ-016 A pixel tick SHALL assert once every PIX_DIV clk cycles, driven by a free-running divider counter.
REQ-017 h_cnt SHALL count 0..799 and v_cnt SHALL count 0..524; both advance on pixel ticks only, and both wrap to 0.
REQ-018 Active area SHALL be h<640 and v<480.
REQ-019 hsync SHALL be 0 for 656<=h<=751; vsync SHALL be 0 for 490<=v<=491.
REQ-020 hsync, vsync and rgb SHALL be registered, changing one pixel tick after the counter value that produced them.
REQ-021 The FSM SHALL have two states: SEARCH and RUN.
REQ-022 SEARCH: each cycle, a head word with flag=0 SHALL be popped and discarded. A head word with flag=1 SHALL be held. On the tick where h=799 and v=524, with a flag=1 word at the head, the FSM SHALL go to RUN.
REQ-023 RUN: on each active-area tick, exactly one word SHALL be popped, and rgb SHALL be set to its colour bits.
REQ-024 RUN, at h=0/v=0: a popped word with flag=0 is an alignment error.
REQ-025 RUN, any other active position: a popped word with flag=1 is an alignment error.
REQ-026 RUN, active tick with the FIFO empty: this is an underrun; rgb SHALL be 0 and no pop occurs.
REQ-027 On an alignment error or underrun: rgb for that pixel SHALL be 0, err_cnt SHALL increment (saturating at 16'hFFFF), and the FSM SHALL go to SEARCH. On an alignment error the offending word has already been popped (an in-flight flag=1 word is therefore lost).
REQ-028 Outside RUN and outside the active area, rgb SHALL be 0.
REQ-029 Register 0 write (cs & write & addr==0): wr_data[0] sets force_blank, and wr_data[1]=1 clears err_cnt.
REQ-030 Simultaneous err_cnt clear and increment: clear wins.
REQ-031 force_blank=1 SHALL drive rgb to 0 only; popping and the FSM SHALL be unaffected.
REQ-032 rd_data SHALL be {state==RUN, 14'b0, force_blank, err_cnt[15:0]}, combinational.
REQ-033 A simultaneous push and pop on a full FIFO SHALL be impossible, because si_ready=0 when full. A simultaneous push and pop on any non-full FIFO SHALL preserve the count.

Reset
REQ-034 While reset_n=0, the following SHALL hold: FSM in SEARCH, FIFO empty, all counters 0, err_cnt=0, force_blank=0, hsync=1, vsync=1, rgb=0. si_ready is then 1 from the first cycle after reset release.
REQ-035 Reset asserted mid-frame SHALL discard the FIFO contents. After release, the FSM SHALL resynchronise via SEARCH and SHALL NOT output stale pixels.

Structure
REQ-036 Package vga_sink_pkg SHALL hold the 640x480 timing constants (H_DISP, H_FP, H_SYNC, H_BP, V_*) and the state enum {SEARCH, RUN}.
REQ-037 The FIFO SHALL be a separate sub-module, stream_fifo #(DW, DEPTH), providing full, empty and show-ahead head data.

Verification
REQ-038 Reset scenario: release reset_n with si_valid=0 -> hsync=1, vsync=1, rgb=0, si_ready=1, rd_data=0.
REQ-039 Aligned frame scenario: stream 307200 words, the first with flag=1 and pixel value = (x+y)&12'hFFF -> the second frame shows rgb=(x+y) at each active pixel, err_cnt=0, and the first hsync low occurs at h=656.
REQ-040 Misaligned start scenario: 5 flag=0 words then an aligned frame -> the 5 words are discarded, display starts at the next frame boundary, err_cnt=0.
REQ-041 Underrun scenario: stop si_valid after 1000 words of a frame -> pixel 1000 shows rgb=0, err_cnt=1, and the state reads SEARCH.
REQ-042 Backpressure scenario: si_valid held at 1 with no pops in SEARCH while holding a flag word -> si_ready=0 after 16 pushes, with no overflow and no data loss.
REQ-043 Register scenario: write wr_data=3 -> rgb=0 while pixels continue to be consumed, err_cnt=0, and rd_data[16]=1.
